sega_pad_poller: RTL and testbench

// - Sequences the open-drain user port (USER_OUT_x/USER_IN_x) to read a Genesis 3- or 6-button pad.
// - Toggles TH through an 8-phase scan, samples the pad lines and detects pad type.
// - Presents an active-high joystick word in the system bitmap (ZYXM SCBAUDLR) to feed emu JOY_x.
// - One instance is built per user port.

---
 rtl/sega_pad_poller.sv | 202 ++++++++++++++++++++
 tb/tb_sega_pad_poller.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sega_pad_poller.sv
`default_nettype none
// ============================================================================
// Module   : sega_pad_poller
// Purpose  : Scans a Genesis 3- or 6-button pad on an open-drain user port.
//            TH is toggled through an 8-phase scan; the pad lines are sampled
//            at the end of each phase, the pad type is identified and an
//            active-high joystick word {Z,Y,X,M,S,C,B,A,U,D,L,R} is published.
// Ports    : clk         - system clock
//            reset       - asynchronous, active-high reset
//            en          - polling enable
//            user_in     - pad pins [1]=U/Z [0]=D/Y [5]=L/X [3]=R/M [2]=TL
//                          [6]=TR [4]=TH (read-back)
//            user_out    - open-drain drive, 1 = released; only TH ever low
//            joy         - joystick word, active high
//            joy_valid   - one-cycle pulse in the cycle joy is refreshed
//            pad_present - pad detected on the last completed scan
//            pad_6btn    - 6-button ID seen on the last completed scan
// Revision : 1.0 - initial release
// ============================================================================
module sega_pad_poller #(
  parameter int PHASE_CYCLES = 500,
  parameter int POLL_CYCLES  = 833333
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [6:0]  user_in,
  output logic [6:0]  user_out,
  output logic [11:0] joy,
  output logic        joy_valid,
  output logic        pad_present,
  output logic        pad_6btn
);

  localparam int PHASE_W = $clog2(PHASE_CYCLES);
  localparam int POLL_W  = $clog2(POLL_CYCLES);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PHASE_CYCLES - 1);
  localparam logic [PHASE_W-1:0] PHASE_ONE  = PHASE_W'(1);
  localparam logic [POLL_W-1:0]  POLL_LAST  = POLL_W'(POLL_CYCLES - 1);
  localparam logic [POLL_W-1:0]  POLL_ONE   = POLL_W'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_P0, S_P1, S_P2, S_P3, S_P4, S_P5, S_P6, S_P7, S_COMMIT
  } state_t;

  state_t               state_q, state_d;
  logic [PHASE_W-1:0]   phase_cnt_q, phase_cnt_d;
  logic [POLL_W-1:0]    poll_cnt_q, poll_cnt_d;
  logic [6:0]           sync1_q, sync1_d;
  logic [6:0]           sync2_q, sync2_d;
  logic [11:0]          word_q, word_d;
  logic                 present_q, present_d;
  logic                 six_q, six_d;
  logic                 th_q, th_d;
  logic [11:0]          joy_q, joy_d;
  logic                 joy_valid_q, joy_valid_d;
  logic                 pad_present_q, pad_present_d;
  logic                 pad_6btn_q, pad_6btn_d;

  // Synchronised pins, renamed by their TH-high meaning (active low).
  logic pin_u, pin_d, pin_l, pin_r, pin_tl, pin_tr;
  logic unused_th_readback;

  assign pin_u  = sync2_q[1];
  assign pin_d  = sync2_q[0];
  assign pin_l  = sync2_q[5];
  assign pin_r  = sync2_q[3];
  assign pin_tl = sync2_q[2];
  assign pin_tr = sync2_q[6];
  // TH is driven here, so its read-back carries no pad information.
  assign unused_th_readback = sync2_q[4];

  always_comb begin
    state_d       = state_q;
    phase_cnt_d   = phase_cnt_q;
    poll_cnt_d    = poll_cnt_q;
    sync1_d       = user_in;
    sync2_d       = sync1_q;
    word_d        = word_q;
    present_d     = present_q;
    six_d         = six_q;
    joy_d         = joy_q;
    joy_valid_d   = 1'b0;
    pad_present_d = pad_present_q;
    pad_6btn_d    = pad_6btn_q;

    case (state_q)
      S_IDLE: begin
        phase_cnt_d = '0;
        if (!en) begin
          poll_cnt_d = '0;
        end else if (poll_cnt_q == POLL_LAST) begin
          poll_cnt_d = '0;
          state_d    = S_P0;
        end else begin
          poll_cnt_d = poll_cnt_q + POLL_ONE;
        end
      end

      S_COMMIT: begin
        phase_cnt_d = '0;
        poll_cnt_d  = '0;
        state_d     = S_IDLE;
      end

      default: begin
        // Scan phases P0..P7. Dropping en abandons the scan outright.
        poll_cnt_d = '0;
        if (!en) begin
          phase_cnt_d = '0;
          state_d     = S_IDLE;
        end else if (phase_cnt_q != PHASE_LAST) begin
          phase_cnt_d = phase_cnt_q + PHASE_ONE;
        end else begin
          phase_cnt_d = '0;
          case (state_q)
            S_P0: begin
              word_d[3] = ~pin_u;
              word_d[2] = ~pin_d;
              word_d[1] = ~pin_l;
              word_d[0] = ~pin_r;
              word_d[5] = ~pin_tl;
              word_d[6] = ~pin_tr;
              state_d   = S_P1;
            end
            S_P1: begin
              word_d[4] = ~pin_tl;
              word_d[7] = ~pin_tr;
              // A pad grounds L and R while TH is low; an empty port floats high.
              present_d = ~pin_l & ~pin_r;
              state_d   = S_P2;
            end
            S_P2: state_d = S_P3;
            S_P3: state_d = S_P4;
            S_P4: state_d = S_P5;
            S_P5: begin
              // Third TH-low of a 6-button pad grounds all four direction lines.
              six_d   = ~(pin_u | pin_d | pin_l | pin_r);
              state_d = S_P6;
            end
            S_P6: begin
              word_d[11:8] = six_q ? ~{pin_u, pin_d, pin_l, pin_r} : 4'h0;
              state_d      = S_P7;
            end
            default: begin
              // End of P7: publish together with the entry into COMMIT so joy
              // and joy_valid change on the same edge.
              joy_d         = present_q ? word_q : 12'h000;
              pad_present_d = present_q;
              pad_6btn_d    = present_q & six_q;
              joy_valid_d   = 1'b1;
              state_d       = S_COMMIT;
            end
          endcase
        end
      end
    endcase

    // TH is low only in the odd scan phases.
    th_d = !(state_d inside {S_P1, S_P3, S_P5, S_P7});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      phase_cnt_q   <= '0;
      poll_cnt_q    <= '0;
      sync1_q       <= 7'h7F;
      sync2_q       <= 7'h7F;
      word_q        <= '0;
      present_q     <= 1'b0;
      six_q         <= 1'b0;
      th_q          <= 1'b1;
      joy_q         <= '0;
      joy_valid_q   <= 1'b0;
      pad_present_q <= 1'b0;
      pad_6btn_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_cnt_q   <= phase_cnt_d;
      poll_cnt_q    <= poll_cnt_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      word_q        <= word_d;
      present_q     <= present_d;
      six_q         <= six_d;
      th_q          <= th_d;
      joy_q         <= joy_d;
      joy_valid_q   <= joy_valid_d;
      pad_present_q <= pad_present_d;
      pad_6btn_q    <= pad_6btn_d;
    end
  end

  assign user_out    = {2'b11, th_q, 4'hF};
  assign joy         = joy_q;
  assign joy_valid   = joy_valid_q;
  assign pad_present = pad_present_q;
  assign pad_6btn    = pad_6btn_q;

endmodule
`default_nettype wire

// File: tb/tb_sega_pad_poller.sv
`default_nettype none
// ============================================================================
// Module   : tb_sega_pad_poller
// Purpose  : Self-checking bench for sega_pad_poller. A behavioural Genesis
//            pad (none / 3-button / 6-button) answers TH on user_in; expected
//            joystick words come from the pad's held-button set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sega_pad_poller;

  localparam int PHASE  = 4;
  localparam int POLL   = 100;
  localparam int PERIOD = POLL + 8 * PHASE + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [6:0]  user_in;
  logic [6:0]  user_out;
  logic [11:0] joy;
  logic        joy_valid;
  logic        pad_present;
  logic        pad_6btn;

  int tests_run    = 0;
  int tests_failed = 0;

  // Pad model state: type 0 = none, 1 = 3-button, 2 = 6-button.
  int          pad_type = 0;
  logic [11:0] btn      = 12'h000;   // held buttons, {Z,Y,X,M,S,C,B,A,U,D,L,R}
  int          falls    = 0;         // TH falling edges since the pad last idled
  int          high_run = 0;
  logic        th_prev  = 1'b1;

  always #5 clk = ~clk;

  sega_pad_poller #(
    .PHASE_CYCLES (PHASE),
    .POLL_CYCLES  (POLL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .user_in     (user_in),
    .user_out    (user_out),
    .joy         (joy),
    .joy_valid   (joy_valid),
    .pad_present (pad_present),
    .pad_6btn    (pad_6btn)
  );

  // 6-button pads count TH falls and forget the count after a long TH-high idle.
  always @(negedge clk) begin
    if (!user_out[4]) begin
      if (th_prev) falls <= falls + 1;
      high_run <= 0;
    end else begin
      high_run <= high_run + 1;
      if (high_run >= 20) falls <= 0;
    end
    th_prev <= user_out[4];
  end

  function automatic logic [6:0] pad_pins(input int typ, input logic [11:0] b,
                                          input int f, input logic th);
    logic [6:0] p;
    p = 7'h7F;
    if (typ != 0) begin
      if (th) begin
        if (typ == 2 && f == 3) begin
          p[1] = ~b[11]; p[0] = ~b[10]; p[5] = ~b[9]; p[3] = ~b[8];
        end else begin
          p[1] = ~b[3];  p[0] = ~b[2];  p[5] = ~b[1]; p[3] = ~b[0];
        end
        p[2] = ~b[5];
        p[6] = ~b[6];
      end else begin
        if (typ == 2 && f == 3) begin
          p[1] = 1'b0; p[0] = 1'b0;
        end else begin
          p[1] = ~b[3]; p[0] = ~b[2];
        end
        p[5] = 1'b0;
        p[3] = 1'b0;
        p[2] = ~b[4];
        p[6] = ~b[7];
      end
    end
    p[4] = th;
    return p;
  endfunction

  assign user_in = pad_pins(pad_type, btn, falls, user_out[4]);

  // Reference: what a completed scan should report for a given pad.
  function automatic logic [11:0] model_joy(input int typ, input logic [11:0] b);
    if (typ == 0) return 12'h000;
    if (typ == 1) return {4'h0, b[7:0]};
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advances until joy_valid is seen; n is the number of edges taken.
  task automatic wait_valid(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 3 * PERIOD) begin
      tick();
      n++;
      if (joy_valid) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    en    = 1'b0;
    repeat (3) tick();
    tests_run++;
    if (user_out !== 7'h7F) begin
      tests_failed++;
      $display("FAIL reset_user_out: got %h want 7f", user_out);
    end
    tests_run++;
    if (joy !== 12'h000 || joy_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_joy: got joy=%h valid=%b want 000/0", joy, joy_valid);
    end
    tests_run++;
    if (pad_present !== 1'b0 || pad_6btn !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_pad: got present=%b six=%b want 0/0", pad_present, pad_6btn);
    end
    reset = 1'b0;
    en    = 1'b1;
  endtask

  task automatic test_3btn();
    int n; bit ok;
    pad_type = 1; btn = 12'h021;       // B + Right
    wait_valid(n, ok);                  // first scan may straddle setup
    wait_valid(n, ok);
    tests_run++;
    if (!ok || joy !== 12'h021 || pad_present !== 1'b1 || pad_6btn !== 1'b0) begin
      tests_failed++;
      $display("FAIL three_btn: got ok=%b joy=%h present=%b six=%b want 1/021/1/0",
               ok, joy, pad_present, pad_6btn);
    end
  endtask

  task automatic test_6btn_th();
    int n; bit ok; int errs; int guard;
    wait_valid(n, ok);
    pad_type = 2; btn = 12'h880;       // Start + Z
    guard = 0;
    while (user_out[4] && guard < 3 * PERIOD) begin
      tick();
      guard++;
    end
    // Now in the first cycle of the first TH-low phase.
    errs = 0;
    for (int k = 0; k < 7 * PHASE; k++) begin
      if (user_out[4] !== (((k / PHASE) % 2) == 1)) errs++;
      if ((user_out & 7'h6F) !== 7'h6F) errs++;
      if (joy_valid !== 1'b0) errs++;
      tick();
    end
    tests_run++;
    if (guard >= 3 * PERIOD || errs != 0) begin
      tests_failed++;
      $display("FAIL th_sequence: got %0d bad cycles (timeout=%0d) want 0", errs, guard >= 3 * PERIOD);
    end
    tests_run++;
    if (joy_valid !== 1'b1 || user_out[4] !== 1'b1) begin
      tests_failed++;
      $display("FAIL commit_after_p7: got valid=%b th=%b want 1/1", joy_valid, user_out[4]);
    end
    tests_run++;
    if (joy !== 12'h880 || pad_6btn !== 1'b1 || pad_present !== 1'b1) begin
      tests_failed++;
      $display("FAIL six_btn: got joy=%h six=%b present=%b want 880/1/1", joy, pad_6btn, pad_present);
    end
  endtask

  task automatic test_no_pad();
    int n; bit ok;
    pad_type = 0; btn = 12'hFFF;
    wait_valid(n, ok);
    wait_valid(n, ok);
    tests_run++;
    if (!ok || joy !== 12'h000 || pad_present !== 1'b0 || pad_6btn !== 1'b0) begin
      tests_failed++;
      $display("FAIL no_pad: got ok=%b joy=%h present=%b six=%b want 1/000/0/0",
               ok, joy, pad_present, pad_6btn);
    end
  endtask

  task automatic test_x_on_3btn();
    int n; bit ok;
    pad_type = 1; btn = 12'h210;       // X + A on a pad that has no X
    wait_valid(n, ok);
    wait_valid(n, ok);
    tests_run++;
    if (!ok || joy !== 12'h010 || joy[9] !== 1'b0) begin
      tests_failed++;
      $display("FAIL x_on_3btn: got ok=%b joy=%h want 1/010", ok, joy);
    end
  endtask

  task automatic test_random();
    int n; bit ok; logic [11:0] b; int typ;
    for (int i = 0; i < 10; i++) begin
      wait_valid(n, ok);
      typ = $urandom_range(0, 2);
      b   = 12'($urandom);
      // A real 3-button pad can't report Up and Down together.
      if (typ == 1 && b[3] && b[2]) b[2] = 1'b0;
      pad_type = typ; btn = b;
      wait_valid(n, ok);
      tests_run++;
      if (!ok || joy !== model_joy(typ, b) || pad_present !== (typ != 0) ||
          pad_6btn !== (typ == 2)) begin
        tests_failed++;
        $display("FAIL random_%0d: type=%0d btn=%h got joy=%h present=%b six=%b want %h/%b/%b",
                 i, typ, b, joy, pad_present, pad_6btn, model_joy(typ, b), typ != 0, typ == 2);
      end
    end
  endtask

  task automatic test_period();
    int n; bit ok;
    wait_valid(n, ok);
    wait_valid(n, ok);
    tests_run++;
    if (!ok || n != PERIOD) begin
      tests_failed++;
      $display("FAIL scan_period: got %0d cycles (ok=%b) want %0d", n, ok, PERIOD);
    end
    tick();
    tests_run++;
    if (joy_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL valid_width: got valid=%b one cycle later want 0", joy_valid);
    end
  endtask

  task automatic test_en_abort();
    int n; bit ok; int guard; int pulses;
    pad_type = 1; btn = 12'h021;
    wait_valid(n, ok);
    wait_valid(n, ok);
    pad_type = 2; btn = 12'h880;       // a commit would now show 880
    guard = 0;
    while (user_out[4] && guard < 3 * PERIOD) begin tick(); guard++; end   // P1
    while (!user_out[4] && guard < 3 * PERIOD) begin tick(); guard++; end  // P2
    while (user_out[4] && guard < 3 * PERIOD) begin tick(); guard++; end   // P3
    tick();
    en = 1'b0;
    tick();
    tests_run++;
    if (guard >= 3 * PERIOD || user_out !== 7'h7F) begin
      tests_failed++;
      $display("FAIL abort_th: got user_out=%h timeout=%0d want 7f", user_out, guard >= 3 * PERIOD);
    end
    pulses = 0;
    for (int k = 0; k < 3 * PERIOD; k++) begin
      if (joy_valid) pulses++;
      tick();
    end
    tests_run++;
    if (pulses != 0 || joy !== 12'h021 || pad_6btn !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_hold: got pulses=%0d joy=%h six=%b want 0/021/0", pulses, joy, pad_6btn);
    end
    en = 1'b1;
    // This cycle is the first idle cycle; the commit cycle is PERIOD cycles on.
    wait_valid(n, ok);
    tests_run++;
    if (!ok || n != PERIOD - 1 || joy !== 12'h880) begin
      tests_failed++;
      $display("FAIL en_restore: got ok=%b edges=%0d joy=%h want 1/%0d/880", ok, n, joy, PERIOD - 1);
    end
  endtask

  task automatic test_reset_mid();
    int n; bit ok; int guard;
    pad_type = 1; btn = 12'h041;       // C + Right
    wait_valid(n, ok);
    guard = 0;
    while (user_out[4] && guard < 3 * PERIOD) begin tick(); guard++; end   // in P1
    #1;
    reset = 1'b1;
    #1;
    tests_run++;
    if (guard >= 3 * PERIOD || user_out !== 7'h7F || joy !== 12'h000 ||
        pad_present !== 1'b0 || joy_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async: got user_out=%h joy=%h present=%b valid=%b want 7f/000/0/0",
               user_out, joy, pad_present, joy_valid);
    end
    tick();
    reset = 1'b0;
    wait_valid(n, ok);
    tests_run++;
    if (!ok || n != PERIOD - 1 || joy !== 12'h041 || pad_present !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_recover: got ok=%b edges=%0d joy=%h present=%b want 1/%0d/041/1",
               ok, n, joy, pad_present, PERIOD - 1);
    end
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    test_reset();
    test_3btn();
    test_6btn_th();
    test_no_pad();
    test_x_on_3btn();
    test_random();
    test_period();
    test_en_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: got no completion want finish before 900000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
